// File: rtl/npu_param_loader.sv
// npu_param_loader: double-buffered weight/bias loader and adder_rst sequencer for NPUCore
// Optional PARAM_CHECKSUM_EN adds param_checksum, a running byte sum of the loaded stream.
module npu_param_loader #(
  parameter int NPU_IN_NUM   = 9,
  parameter int NPU_OUT_NUM  = 18,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH   = 16,
  parameter int IN_BUS_WIDTH = NPU_IN_NUM*WEIGHT_WIDTH,
  parameter int ACC_LEN_W    = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         load_start,
  input  logic [IN_BUS_WIDTH-1:0]                      s_data,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic                                         swap_req,
  output logic                                         swap_done,
  output logic                                         shadow_full,
  input  logic [ACC_LEN_W-1:0]                         cfg_acc_len,
  input  logic                                         data_valid_in,
  output logic [NPU_IN_NUM*WEIGHT_WIDTH*NPU_OUT_NUM-1:0] NPU_weight_out,
  output logic                                         NPU_weight_valid_out,
  output logic [BIAS_WIDTH*NPU_OUT_NUM-1:0]            NPU_bias_out,
  output logic                                         NPU_bias_valid_out,
`ifdef PARAM_CHECKSUM_EN
  output logic [15:0]                                  param_checksum,
`endif
  output logic [NPU_OUT_NUM-1:0]                       adder_rst
);
  localparam int CH_W = NPU_IN_NUM*WEIGHT_WIDTH;
  localparam int BPB  = IN_BUS_WIDTH/BIAS_WIDTH;
  localparam int NB   = (NPU_OUT_NUM+BPB-1)/BPB;
  localparam int CW   = $clog2(NPU_OUT_NUM+1);
  localparam logic [1:0] S_IDLE = 2'd0, S_LW = 2'd1, S_LB = 2'd2, S_FULL = 2'd3;
  logic [1:0] r_state, w_nstate;
  logic [CW-1:0] r_beat;
  logic r_pend, r_valid, r_swap_done;
  logic [ACC_LEN_W-1:0] r_cnt, r_len, w_len;
  logic [CH_W*NPU_OUT_NUM-1:0] r_sh_w, r_act_w;
  logic [BIAS_WIDTH*NPU_OUT_NUM-1:0] r_sh_b, r_act_b;
  logic w_acc, w_swap, w_start, w_last_w, w_last_b, w_beat_end;
  assign s_ready = r_state == S_LW || r_state == S_LB;
  assign shadow_full = r_state == S_FULL;
  assign w_acc = s_valid & s_ready;
  // never swap mid-group so a group is computed with a single weight set
  assign w_swap = r_pend & shadow_full & (r_cnt == '0);
  assign w_start = load_start & (r_state == S_IDLE | w_swap);
  assign w_last_w = r_beat == CW'(NPU_OUT_NUM-1);
  assign w_last_b = r_beat == CW'(NB-1);
  assign w_beat_end = w_acc & (r_state == S_LW ? w_last_w : w_last_b);
  assign w_len = (r_cnt != '0) ? r_len : (cfg_acc_len == '0) ? ACC_LEN_W'(1) : cfg_acc_len;
  assign adder_rst = {NPU_OUT_NUM{data_valid_in & (r_cnt == '0)}};
  assign swap_done = r_swap_done;
  assign NPU_weight_out = r_act_w;
  assign NPU_bias_out = r_act_b;
  assign NPU_weight_valid_out = r_valid;
  assign NPU_bias_valid_out = r_valid;
  always_comb begin
    w_nstate = w_start ? S_LW :
               w_swap ? S_IDLE :
               (r_state == S_LW && w_beat_end) ? S_LB :
               (r_state == S_LB && w_beat_end) ? S_FULL : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat <= '0;
      r_pend <= 1'b0;
      r_swap_done <= 1'b0;
      r_valid <= 1'b0;
      r_cnt <= '0;
      r_len <= '0;
    end else begin
      r_state <= w_nstate;
      r_beat <= (w_start || w_beat_end) ? '0 : r_beat + CW'(w_acc);
      r_pend <= w_swap ? 1'b0 : r_pend | (swap_req & (r_state != S_IDLE));
      r_swap_done <= w_swap;
      r_valid <= r_valid | w_swap;
      if (data_valid_in) begin
        r_cnt <= (r_cnt == w_len - ACC_LEN_W'(1)) ? '0 : r_cnt + ACC_LEN_W'(1);
        r_len <= w_len;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_w <= '0;
      r_sh_b <= '0;
      r_act_w <= '0;
      r_act_b <= '0;
    end else begin
      for (int p = 0; p < NPU_OUT_NUM; p++)
        if (w_acc && r_state == S_LW && r_beat == CW'(p))
          r_sh_w[p*CH_W+:CH_W] <= s_data[CH_W-1:0];
      // bias k lives in beat k/BPB, slot k%BPB; spare slots of the last beat are dropped
      for (int k = 0; k < NPU_OUT_NUM; k++)
        if (w_acc && r_state == S_LB && r_beat == CW'(k/BPB))
          r_sh_b[k*BIAS_WIDTH+:BIAS_WIDTH] <= s_data[(k%BPB)*BIAS_WIDTH+:BIAS_WIDTH];
      if (w_swap) begin
        r_act_w <= r_sh_w;
        r_act_b <= r_sh_b;
      end
    end
  end
`ifdef PARAM_CHECKSUM_EN
  logic [15:0] r_cks, w_cks;
  always_comb begin
    w_cks = r_cks;
    for (int i = 0; i < IN_BUS_WIDTH/8; i++) w_cks = w_cks + 16'(s_data[i*8+:8]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cks <= '0;
    else if (w_start) r_cks <= '0;
    else if (w_acc) r_cks <= w_cks;
  end
  assign param_checksum = r_cks;
`endif
endmodule
